// File: rtl/snap_ctrl.sv
// snap_ctrl: snapshot capture controller for the user_clk domain.
// A rising edge on the start bit arms a capture of DEPTH qualified samples
// into a snapshot BRAM, optionally gated by an external trigger; progress
// and completion are reported through a registered status word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a start edge, nothing captured since reset
// ARMED   | start accepted with trigger select, waiting for trig_in
// CAPTURE | writing qualified samples to consecutive BRAM addresses
// DONE    | DEPTH samples written, waiting for a new start edge
module snap_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  input  logic              trig_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status_out
);

  // Terminal count: the write of this address completes the capture.
  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              start_d;
  logic              start_pulse;
  logic              trig_sel_q;
  logic              vld_sel_q;
  logic              qual;
  logic              accept;
  logic              write_en;
  logic [ADDR_W:0]   cnt;
  logic [31:0]       status_d;

  // Control bits above vld_sel carry no meaning for this block.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_in[31:3], trig_sel_q};

  assign start_pulse = ctrl_in[0] & ~start_d;
  assign qual        = vld_sel_q ? data_vld : 1'b1;
  assign accept      = start_pulse && ((state == IDLE) || (state == DONE));
  assign write_en    = (state == CAPTURE) && qual;

  // State register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; start edges are only honoured while not busy.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_d = ctrl_in[1] ? ARMED : CAPTURE;
      end
      ARMED: begin
        if (trig_in) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (qual && (cnt == CNT_LAST)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Start edge detector; resets high so a start bit left set across reset is not an edge.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      start_d <= 1'b1;
    end else begin
      start_d <= ctrl_in[0];
    end
  end

  // Capture options are frozen for the whole capture when a start is accepted.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      trig_sel_q <= 1'b0;
      vld_sel_q  <= 1'b0;
    end else if (accept) begin
      trig_sel_q <= ctrl_in[1];
      vld_sel_q  <= ctrl_in[2];
    end
  end

  // Sample counter: cleared on an accepted start, advances once per qualified sample.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (write_en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // BRAM write port: one registered write per qualified sample, address/data hold otherwise.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      bram_addr <= '0;
      bram_data <= '0;
      bram_we   <= 1'b0;
    end else begin
      bram_we <= write_en;
      if (write_en) begin
        bram_addr <= cnt[ADDR_W-1:0];
        bram_data <= data_in;
      end
    end
  end

  // Status word assembly: done, busy and samples-written count.
  always_comb begin
    status_d           = '0;
    status_d[ADDR_W:0] = cnt;
    status_d[30]       = (state == ARMED) || (state == CAPTURE);
    status_d[31]       = (state == DONE);
  end

  // Registered status readback, one cycle behind state and counter.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      status_out <= '0;
    end else begin
      status_out <= status_d;
    end
  end

endmodule

// File: tb/tb_snap_ctrl.sv
// Bench for snap_ctrl with a 16-deep capture: randomized sample data,
// qualifiers and triggers against a behavioural capture model; expected
// BRAM writes are queued by the driver and consumed by a write monitor.
module tb_snap_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b0;
  logic [31:0]   ctrl_in  = '0;
  logic [DW-1:0] data_in  = '0;
  logic          data_vld = 1'b0;
  logic          trig_in  = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic [31:0]   status_out;

  int total = 0;
  int bad   = 0;

  logic [AW+DW-1:0] exp_q[$];

  // Behavioural model: what software would expect to see.
  bit m_prev  = 1'b1;
  bit m_armed = 1'b0;
  bit m_cap   = 1'b0;
  bit m_fin   = 1'b0;
  bit m_vsel  = 1'b0;
  int m_n     = 0;

  snap_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl_in   (ctrl_in),
    .data_in   (data_in),
    .data_vld  (data_vld),
    .trig_in   (trig_in),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .bram_we   (bram_we),
    .status_out(status_out)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[AW:0]  = m_n[AW:0];
    s[30]    = m_armed | m_cap;
    s[31]    = m_fin;
    return s;
  endfunction

  // One clock: advance the model with the inputs the DUT is about to sample,
  // then check the registered status (which reflects the pre-edge model).
  task automatic step();
    logic [31:0] es;
    bit sp;
    es     = model_status();
    sp     = ctrl_in[0] & ~m_prev;
    m_prev = ctrl_in[0];
    if (m_cap) begin
      if (!m_vsel || data_vld) begin
        exp_q.push_back({AW'(m_n), data_in});
        m_n++;
        if (m_n == DEPTH) begin
          m_cap = 1'b0;
          m_fin = 1'b1;
        end
      end
    end else if (m_armed) begin
      if (trig_in) begin
        m_armed = 1'b0;
        m_cap   = 1'b1;
      end
    end else if (sp) begin
      m_n    = 0;
      m_fin  = 1'b0;
      m_vsel = ctrl_in[2];
      if (ctrl_in[1]) m_armed = 1'b1;
      else            m_cap   = 1'b1;
    end
    @(posedge user_clk);
    #1;
    check("status", status_out, es);
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    #1;
    check("we_at_reset", bram_we, 1'b0);
    check("status_at_reset", status_out, 32'h0);
    exp_q.delete();
    m_prev  = 1'b1;
    m_armed = 1'b0;
    m_cap   = 1'b0;
    m_fin   = 1'b0;
    m_vsel  = 1'b0;
    m_n     = 0;
    repeat (3) @(posedge user_clk);
    #1;
    user_rst = 1'b0;
  endtask

  // Write monitor: every BRAM write must match the oldest expected sample.
  always @(negedge user_clk) begin
    logic [AW+DW-1:0] e;
    if (bram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", bram_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("bram_addr", bram_addr, e[AW+DW-1:DW]);
        check("bram_data", bram_data, e[DW-1:0]);
      end
    end
  end

  initial begin
    #2;
    // Start bit held high through reset must not launch a capture.
    ctrl_in = 32'h1;
    do_reset();
    repeat (10) step();
    check("idle_after_rst", status_out, 32'h0);

    // Immediate capture of an incrementing stream; start stays high afterwards.
    ctrl_in = 32'h0;
    step();
    ctrl_in = 32'h1;
    data_in = $urandom;
    step();
    for (int i = 0; i < 25; i++) begin
      data_in  = 32'h100 + i;
      data_vld = 1'($urandom);
      step();
    end
    check("imm_done", status_out, 32'h80000010);

    // Re-arm from DONE with a fresh start edge.
    ctrl_in = 32'h0;
    step();
    ctrl_in = 32'h1;
    step();
    for (int i = 0; i < 20; i++) begin
      data_in = $urandom;
      step();
    end
    check("rearm_done", status_out, 32'h80000010);

    // Triggered capture: long armed wait, one trigger pulse.
    ctrl_in = 32'h0;
    step();
    ctrl_in = 32'h3;
    step();
    for (int i = 0; i < 50; i++) begin
      data_in = $urandom;
      step();
    end
    check("armed_busy", status_out, 32'h40000000);
    trig_in = 1'b1;
    data_in = $urandom;
    step();
    trig_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_in = $urandom;
      trig_in = 1'($urandom);
      step();
    end
    check("trig_done", status_out, 32'h80000010);

    // Valid-qualified capture with an alternating qualifier.
    ctrl_in = 32'h0;
    trig_in = 1'b0;
    step();
    ctrl_in = 32'h5;
    step();
    for (int i = 0; i < 40; i++) begin
      data_vld = (i % 2 == 0);
      data_in  = $urandom;
      step();
    end
    check("vld_done", status_out, 32'h80000010);

    // Random option mixes; first round keeps the trigger high throughout.
    for (int r = 0; r < 6; r++) begin
      ctrl_in = 32'h0;
      step();
      ctrl_in = {$urandom} & 32'hFFFF_FFF8 | {29'd0, 1'($urandom), 1'($urandom), 1'b1};
      for (int i = 0; i < 60; i++) begin
        data_in  = $urandom;
        data_vld = ($urandom_range(0, 3) != 0);
        trig_in  = (r == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
        step();
      end
    end

    // Reset in the middle of a capture, then a clean restart from address 0.
    ctrl_in  = 32'h0;
    trig_in  = 1'b0;
    data_vld = 1'b1;
    step();
    ctrl_in = 32'h1;
    step();
    for (int i = 0; i < 20 && m_n < 5; i++) begin
      data_in = $urandom;
      step();
    end
    do_reset();
    repeat (3) step();
    ctrl_in = 32'h0;
    step();
    ctrl_in = 32'h1;
    step();
    for (int i = 0; i < 20; i++) begin
      data_in = $urandom;
      step();
    end
    check("restart_done", status_out, 32'h80000010);

    repeat (3) step();
    check("pending_writes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
